// File: rtl/adder_traffic_gen.sv
// adder_traffic_gen: LFSR-driven operand initiator and result checker for the
// adder valid/ready wrapper. Keeps one transaction outstanding at a time,
// counts results and mismatches, and aborts a run through a watchdog when the
// responder stalls.
module adder_traffic_gen #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RES_WIDTH = WIDTH + 1,
  parameter int unsigned NUM_TX    = 16,
  parameter logic [31:0] SEED      = 32'h0000_0001,
  parameter int unsigned TIMEOUT   = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     op_a,
  output logic [WIDTH-1:0]     op_b,
  output logic                 op_valid,
  input  logic                 op_ready,
  input  logic [RES_WIDTH-1:0] res_data,
  input  logic                 res_valid,
  output logic                 res_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [15:0]          tx_count,
  output logic [15:0]          err_count
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
  // The watchdog only needs to reach TIMEOUT-1; the expiring edge is the next one.
  localparam int unsigned WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, COLLECT, DONE} state_t;

  state_t               state_reg, state_next;
  logic [31:0]          lfsr_reg, lfsr_next, lfsr_adv;
  logic [WD_W-1:0]      wd_reg, wd_next;
  logic [RES_WIDTH-1:0] expected_reg, expected_next;
  logic [WIDTH-1:0]     op_a_next, op_b_next;
  logic                 op_valid_next, res_ready_next, busy_next, done_next, timeout_next;
  logic [15:0]          tx_count_next, err_count_next, tx_inc;
  logic                 abort_now;

  // Fibonacci LFSR, taps 32/22/2/1, shifting left with feedback into bit 0.
  assign lfsr_adv = {lfsr_reg[30:0], lfsr_reg[31] ^ lfsr_reg[21] ^ lfsr_reg[1] ^ lfsr_reg[0]};
  assign tx_inc   = tx_count + 16'd1;

  // Next-state and registered-output logic for the run sequencer.
  always_comb begin
    state_next     = state_reg;
    lfsr_next      = lfsr_reg;
    wd_next        = wd_reg;
    expected_next  = expected_reg;
    op_a_next      = op_a;
    op_b_next      = op_b;
    op_valid_next  = op_valid;
    res_ready_next = res_ready;
    busy_next      = busy;
    done_next      = done;
    timeout_next   = timeout;
    tx_count_next  = tx_count;
    err_count_next = err_count;
    abort_now      = 1'b0;

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          tx_count_next  = 16'd0;
          err_count_next = 16'd0;
          timeout_next   = 1'b0;
          done_next      = 1'b0;
          busy_next      = 1'b1;
          op_a_next      = lfsr_reg[WIDTH-1:0];
          op_b_next      = lfsr_reg[16+WIDTH-1:16];
          op_valid_next  = 1'b1;
          wd_next        = '0;
          state_next     = DRIVE;
        end
      end
      DRIVE: begin
        if (op_valid && op_ready) begin
          expected_next  = RES_WIDTH'(op_a) + RES_WIDTH'(op_b);
          op_valid_next  = 1'b0;
          res_ready_next = 1'b1;
          lfsr_next      = lfsr_adv;
          wd_next        = '0;
          state_next     = COLLECT;
        end else if (wd_reg == WD_LAST) begin
          abort_now = 1'b1;
        end else begin
          wd_next = wd_reg + WD_W'(1);
        end
      end
      COLLECT: begin
        if (res_valid && res_ready) begin
          res_ready_next = 1'b0;
          tx_count_next  = tx_inc;
          if ((res_data != expected_reg) && (err_count != 16'hFFFF)) begin
            err_count_next = err_count + 16'd1;
          end
          wd_next = '0;
          if (tx_inc == 16'(NUM_TX)) begin
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = DONE;
          end else begin
            // LFSR already advanced at the operand handshake.
            op_a_next     = lfsr_reg[WIDTH-1:0];
            op_b_next     = lfsr_reg[16+WIDTH-1:16];
            op_valid_next = 1'b1;
            state_next    = DRIVE;
          end
        end else if (wd_reg == WD_LAST) begin
          abort_now = 1'b1;
        end else begin
          wd_next = wd_reg + WD_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // Watchdog expiry: drop both handshakes, keep partial counts, flag timeout.
    if (abort_now) begin
      op_valid_next  = 1'b0;
      res_ready_next = 1'b0;
      busy_next      = 1'b0;
      done_next      = 1'b1;
      timeout_next   = 1'b1;
      wd_next        = '0;
      state_next     = DONE;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      lfsr_reg     <= SEED_EFF;
      wd_reg       <= '0;
      expected_reg <= '0;
      op_a         <= '0;
      op_b         <= '0;
      op_valid     <= 1'b0;
      res_ready    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      tx_count     <= 16'd0;
      err_count    <= 16'd0;
    end else begin
      state_reg    <= state_next;
      lfsr_reg     <= lfsr_next;
      wd_reg       <= wd_next;
      expected_reg <= expected_next;
      op_a         <= op_a_next;
      op_b         <= op_b_next;
      op_valid     <= op_valid_next;
      res_ready    <= res_ready_next;
      busy         <= busy_next;
      done         <= done_next;
      timeout      <= timeout_next;
      tx_count     <= tx_count_next;
      err_count    <= err_count_next;
    end
  end

endmodule

// File: tb/tb_adder_traffic_gen.sv
// tb_adder_traffic_gen: randomized responder around adder_traffic_gen with a
// behavioural operand/sum model; one line per completed transaction.
module tb_adder_traffic_gen;

  localparam int          W    = 8;
  localparam int          RW   = 9;
  localparam int          NTX  = 4;
  localparam int          TMO  = 16;
  localparam logic [31:0] SEED = 32'h0000_0001;

  logic          clk, rst_n, start;
  logic [W-1:0]  op_a, op_b;
  logic          op_valid, op_ready;
  logic [RW-1:0] res_data;
  logic          res_valid, res_ready;
  logic          busy, done, timeout;
  logic [15:0]   tx_count, err_count;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] model_lfsr;

  adder_traffic_gen #(
    .WIDTH(W), .RES_WIDTH(RW), .NUM_TX(NTX), .SEED(SEED), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .done(done), .timeout(timeout),
    .tx_count(tx_count), .err_count(err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL global_time_limit: got running, expected finished");
    $fatal(1);
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference LFSR step written from the tap list (positions 32,22,2,1).
  function automatic logic [31:0] model_step(input logic [31:0] s);
    int taps[4] = '{32, 22, 2, 1};
    logic fb = 1'b0;
    foreach (taps[i]) fb = fb ^ s[taps[i]-1];
    return {s[30:0], fb};
  endfunction

  function automatic logic [7:0] model_a();
    return model_lfsr[7:0];
  endfunction

  function automatic logic [7:0] model_b();
    return model_lfsr[23:16];
  endfunction

  // Expected result: (A + B) mod 2^RW.
  function automatic logic [8:0] model_sum();
    return 9'((int'(model_a()) + int'(model_b())) % 512);
  endfunction

  // One transaction with an ideal responder; caller is at posedge+1 in DRIVE.
  task automatic ideal_tx(input string tag);
    logic [8:0] s;
    check_value({tag, " op_valid"}, 32'(op_valid), 32'd1);
    check_value({tag, " op_a"}, 32'(op_a), 32'(model_a()));
    check_value({tag, " op_b"}, 32'(op_b), 32'(model_b()));
    s = model_sum();
    op_ready = 1'b1;
    @(posedge clk); #1;
    op_ready = 1'b0;
    $display("%s tx a=%02h b=%02h res=%03h", tag, model_a(), model_b(), s);
    model_lfsr = model_step(model_lfsr);
    res_valid = 1'b1;
    res_data  = s;
    @(posedge clk); #1;
    res_valid = 1'b0;
  endtask

  // Full run with a cycle-accurate responder. corrupt_idx flips bit 0 of that
  // result (0-based); trunc drops the carry; start_at re-pulses start mid-run.
  task automatic run_traffic(input string tag, input bit ideal, input int stall_first,
                             input int corrupt_idx, input bit trunc, input int start_at);
    int         cycles = 0, returned = 0, exp_err = 0, stall = stall_first, delay = 0;
    bit         pend = 1'b0, rr_prev = 1'b0;
    logic [8:0] pend_sum = '0;
    logic [7:0] pa = '0, pb = '0;
    res_valid = 1'b0;
    op_ready  = 1'b0;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_value({tag, " start busy"}, 32'(busy), 32'd1);
    check_value({tag, " start done"}, 32'(done), 32'd0);
    check_value({tag, " start timeout"}, 32'(timeout), 32'd0);
    while (cycles < 400) begin
      cycles++;
      if (res_valid && rr_prev && pend) begin
        if (res_data != pend_sum) exp_err++;
        $display("%s tx%0d a=%02h b=%02h res=%03h exp=%03h", tag, returned, pa, pb, res_data, pend_sum);
        returned++;
        pend = 1'b0;
      end
      check_value({tag, " tx_count"}, 32'(tx_count), 32'(returned));
      check_value({tag, " err_count"}, 32'(err_count), 32'(exp_err));
      check_value({tag, " res_ready"}, 32'(res_ready), 32'(pend));
      if (done) break;
      check_value({tag, " busy"}, 32'(busy), 32'd1);
      check_value({tag, " op_valid"}, 32'(op_valid), 32'(!pend));
      start = (cycles == start_at);
      // result channel
      res_valid = 1'b0;
      if (pend) begin
        if (delay > 0) delay--;
        else begin
          res_valid = 1'b1;
          res_data  = pend_sum;
          if (returned == corrupt_idx) res_data = pend_sum ^ 9'h001;
          if (trunc) res_data = {1'b0, pend_sum[7:0]};
        end
      end else begin
        res_valid = ($urandom_range(0, 3) == 0);
        res_data  = RW'($urandom);
      end
      // operand channel
      if (op_valid) begin
        check_value({tag, " op_a"}, 32'(op_a), 32'(model_a()));
        check_value({tag, " op_b"}, 32'(op_b), 32'(model_b()));
        if (stall > 0) begin
          op_ready = 1'b0;
          stall--;
        end else begin
          op_ready = ideal ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
        if (op_ready) begin
          pend       = 1'b1;
          pa         = model_a();
          pb         = model_b();
          pend_sum   = model_sum();
          model_lfsr = model_step(model_lfsr);
          delay      = ideal ? 0 : int'($urandom_range(0, 3));
        end
      end else begin
        op_ready = ($urandom_range(0, 1) == 1);
      end
      rr_prev = res_ready;
      @(posedge clk); #1;
    end
    start     = 1'b0;
    op_ready  = 1'b0;
    res_valid = 1'b0;
    check_value({tag, " end done"}, 32'(done), 32'd1);
    check_value({tag, " end timeout"}, 32'(timeout), 32'd0);
    check_value({tag, " end busy"}, 32'(busy), 32'd0);
    check_value({tag, " end tx_count"}, 32'(tx_count), 32'(NTX));
    @(posedge clk); #1;
    check_value({tag, " held done"}, 32'(done), 32'd1);
    check_value({tag, " held err_count"}, 32'(err_count), 32'(exp_err));
    check_value({tag, " held op_valid"}, 32'(op_valid), 32'd0);
  endtask

  // Operands accepted but no result ever returned: watchdog fires 16 cycles later.
  task automatic timeout_test();
    bool_loop: begin end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_value("tmo op_a", 32'(op_a), 32'(model_a()));
    op_ready = 1'b1;
    @(posedge clk); #1;
    op_ready   = 1'b0;
    model_lfsr = model_step(model_lfsr);
    $display("tmo tx accepted, result withheld");
    for (int i = 1; i < TMO; i++) begin
      @(posedge clk); #1;
      check_value("tmo wait done", 32'(done), 32'd0);
      check_value("tmo wait res_ready", 32'(res_ready), 32'd1);
    end
    @(posedge clk); #1;
    check_value("tmo done", 32'(done), 32'd1);
    check_value("tmo timeout", 32'(timeout), 32'd1);
    check_value("tmo res_ready", 32'(res_ready), 32'd0);
    check_value("tmo busy", 32'(busy), 32'd0);
    check_value("tmo tx_count", 32'(tx_count), 32'd0);
    check_value("tmo op_valid", 32'(op_valid), 32'd0);
  endtask

  // Asynchronous reset while collecting, then a restart from the seed.
  task automatic reset_test();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ideal_tx("rst");
    ideal_tx("rst");
    check_value("rst pre tx_count", 32'(tx_count), 32'd2);
    op_ready = 1'b1;
    @(posedge clk); #1;
    op_ready = 1'b0;
    check_value("rst pre res_ready", 32'(res_ready), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_value("rst async res_ready", 32'(res_ready), 32'd0);
    check_value("rst async busy", 32'(busy), 32'd0);
    check_value("rst async tx_count", 32'(tx_count), 32'd0);
    check_value("rst async op_valid", 32'(op_valid), 32'd0);
    #2 rst_n = 1'b1;
    model_lfsr = SEED;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_value("rst restart op_a", 32'(op_a), 32'h01);
    check_value("rst restart op_b", 32'(op_b), 32'h00);
    repeat (NTX) ideal_tx("rst2");
    check_value("rst2 done", 32'(done), 32'd1);
    check_value("rst2 tx_count", 32'(tx_count), 32'(NTX));
    check_value("rst2 err_count", 32'(err_count), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    op_ready  = 1'b0;
    res_valid = 1'b0;
    res_data  = '0;
    model_lfsr = SEED;
    @(posedge clk); #1;
    check_value("reset op_valid", 32'(op_valid), 32'd0);
    check_value("reset res_ready", 32'(res_ready), 32'd0);
    check_value("reset busy", 32'(busy), 32'd0);
    check_value("reset done", 32'(done), 32'd0);
    check_value("reset timeout", 32'(timeout), 32'd0);
    check_value("reset op_a", 32'(op_a), 32'd0);
    check_value("reset op_b", 32'(op_b), 32'd0);
    check_value("reset tx_count", 32'(tx_count), 32'd0);
    check_value("reset err_count", 32'(err_count), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    // A stray result while idle must be ignored.
    res_valid = 1'b1;
    res_data  = 9'h1AA;
    @(posedge clk); #1;
    res_valid = 1'b0;
    check_value("idle res_ready", 32'(res_ready), 32'd0);
    check_value("idle tx_count", 32'(tx_count), 32'd0);
    check_value("idle first op_a model", 32'(model_a()), 32'h01);

    run_traffic("ideal", 1'b1, 0, -1, 1'b0, -1);
    run_traffic("corrupt2", 1'b1, 0, 1, 1'b0, -1);
    run_traffic("trunc", 1'b0, 0, -1, 1'b1, -1);
    run_traffic("stall", 1'b1, 10, -1, 1'b0, 3);
    timeout_test();
    run_traffic("after_tmo", 1'b0, 0, -1, 1'b0, -1);
    reset_test();
    for (int r = 0; r < 6; r++) begin
      run_traffic("rand", 1'b0, 0, int'($urandom_range(0, 4)) - 1, ($urandom_range(0, 3) == 0),
                  int'($urandom_range(2, 9)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
